// File: rtl/io_timer_sched.sv
// Multiplexed virtual timer channels sharing one tick counter and one comparator,
// with round-robin presentation of expired channels on a single IRQ line.
module io_timer_sched #(
    parameter int CChCnt = 4,
    parameter int CCntW  = 16
) (
    input  logic              AClkH,
    input  logic              AResetH,
    input  logic              AClkHEn,
    input  logic              ASync1K,
    input  logic              ACfgWr,
    input  logic [2:0]        ACfgCh,
    input  logic [1:0]        ACfgMode,
    input  logic [CCntW-1:0]  ACfgPeriod,
    input  logic              AAckWr,
    input  logic [2:0]        AAckCh,
    output logic              AIrq,
    output logic [2:0]        AIrqCh,
    output logic [CChCnt-1:0] AOvr,
    output logic [CCntW-1:0]  ATime
);

    localparam logic [1:0] ModeOff = 2'd0;
    localparam logic [1:0] ModeOne = 2'd1;
    localparam logic [1:0] ModePer = 2'd2;

    logic [CCntW-1:0]  fTime;
    logic [CChCnt-1:0] fPend;
    logic [CChCnt-1:0] fOvr;
    logic [CChCnt-1:0] scanSel;
    logic [2:0]        scanIdx;
    logic [2:0]        scanIdxNext;
    logic [2:0]        rrPtr;
    logic [2:0]        selCh;
    logic              selValid;
    logic              cfgArm;

    assign cfgArm = (ACfgMode == 2'b01) || (ACfgMode == 2'b10);

    // Time base
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            fTime <= '0;
        end else if (AClkHEn && ASync1K) begin
            fTime <= fTime + CCntW'(1);
        end
    end

    // Scan FSM: state register, next-state and one-hot channel select
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            scanIdx <= '0;
        end else if (AClkHEn) begin
            scanIdx <= scanIdxNext;
        end
    end

    always_comb begin
        scanIdxNext = (scanIdx == 3'(CChCnt - 1)) ? 3'd0 : scanIdx + 3'd1;
    end

    always_comb begin
        scanSel = '0;
        for (int i = 0; i < CChCnt; i++) begin
            scanSel[i] = (scanIdx == 3'(i));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CChCnt; gi++) begin : gCh
            logic [1:0]       mode;
            logic [CCntW-1:0] deadline;
            logic [CCntW-1:0] period;
            logic             pend;
            logic             ovr;
            logic             cfgHere;
            logic             ackHere;
            logic             hit;

            assign cfgHere = ACfgWr && (ACfgCh == 3'(gi));
            assign ackHere = AAckWr && (AAckCh == 3'(gi));
            assign hit     = scanSel[gi] && (mode != ModeOff) && (deadline == fTime);

            // Configuration beats a simultaneous hit; a hit beats a simultaneous ack.
            always_ff @(posedge AClkH) begin
                if (AResetH) begin
                    mode     <= ModeOff;
                    deadline <= '0;
                    period   <= '0;
                    pend     <= 1'b0;
                    ovr      <= 1'b0;
                end else if (AClkHEn) begin
                    if (cfgHere) begin
                        pend <= 1'b0;
                        if (cfgArm) begin
                            deadline <= fTime + ACfgPeriod;
                            period   <= ACfgPeriod;
                            mode     <= (ACfgPeriod == '0) ? ModeOne : ACfgMode;
                            ovr      <= 1'b0;
                        end else begin
                            mode <= ModeOff;
                        end
                    end else if (hit) begin
                        pend <= 1'b1;
                        if (pend && !ackHere) begin
                            ovr <= 1'b1;
                        end
                        if (mode == ModePer) begin
                            deadline <= deadline + period;
                        end else begin
                            mode <= ModeOff;
                        end
                    end else if (ackHere) begin
                        pend <= 1'b0;
                    end
                end
            end

            assign fPend[gi] = pend;
            assign fOvr[gi]  = ovr;
        end
    endgenerate

    // Round-robin: first pending channel after the pointer, wrapping modulo CChCnt
    always_comb begin
        logic [3:0]        idx;
        logic [CChCnt-1:0] pendShift;
        selValid  = 1'b0;
        selCh     = rrPtr;
        idx       = '0;
        pendShift = '0;
        for (int k = 1; k <= CChCnt; k++) begin
            idx = {1'b0, rrPtr} + 4'(k);
            if (idx >= 4'(CChCnt)) begin
                idx = idx - 4'(CChCnt);
            end
            pendShift = fPend >> idx;
            if (!selValid && pendShift[0]) begin
                selValid = 1'b1;
                selCh    = idx[2:0];
            end
        end
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            AIrq   <= 1'b0;
            AIrqCh <= '0;
            rrPtr  <= 3'(CChCnt - 1);
        end else if (AClkHEn) begin
            AIrq <= |fPend;
            if (selValid) begin
                AIrqCh <= selCh;
            end
            if (AAckWr && ({1'b0, AAckCh} < 4'(CChCnt))) begin
                rrPtr <= AAckCh;
            end
        end
    end

    assign AOvr  = fOvr;
    assign ATime = fTime;

endmodule
